// File: rtl/countdown_timer_pkg.sv
// rtl/countdown_timer_pkg.sv - shared states, BCD constants and digit check for the countdown controller
package countdown_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_PAUSE,
    ST_EXPIRED
  } timer_state_t;

  localparam logic [7:0] BCD_MAX  = 8'h99;
  localparam logic [7:0] BCD_ZERO = 8'h00;

  // True when both nibbles hold a legal decimal digit
  function automatic logic bcdDigitsValid(input logic [7:0] value);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_sat_adder.sv
// rtl/bcd_sat_adder.sv - two-digit BCD adder clamped at 99, flags a legal addendB
module bcd_sat_adder
  import countdown_timer_pkg::*;
(
  input  logic [7:0] addendA,
  input  logic [7:0] addendB,
  output logic [7:0] sum,
  output logic       inValid
);

  logic [4:0] lowSum;
  logic [4:0] highSum;
  logic       lowCarry;
  logic [3:0] lowDigit;

  // Units digit with decimal carry, then tens digit; a tens overflow clamps to 99
  always_comb begin
    lowSum   = {1'b0, addendA[3:0]} + {1'b0, addendB[3:0]};
    lowCarry = (lowSum > 5'd9);
    lowDigit = lowCarry ? 4'(lowSum - 5'd10) : lowSum[3:0];
    highSum  = {1'b0, addendA[7:4]} + {1'b0, addendB[7:4]} + {4'd0, lowCarry};
    sum      = (highSum > 5'd9) ? BCD_MAX : {highSum[3:0], lowDigit};
    inValid  = bcdDigitsValid(addendB);
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - game countdown sequencer: load, 1 s strobe, pause, bonus, warning, expiry
module countdown_timer_ctrl
  import countdown_timer_pkg::*;
#(
  parameter int         CLKS_PER_SEC = 50_000_000,
  parameter logic [7:0] INIT_TIME    = 8'h60,
  parameter logic [7:0] WARN_TIME    = 8'h10
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic       pause_toggle,
  input  logic       bonus_req,
  input  logic [7:0] bonus_bcd,
  input  logic [7:0] count_bcd,
  output logic       cnt_ena,
  output logic       cnt_ena_cnt,
  output logic       cnt_loadN,
  output logic [7:0] cnt_data,
  output logic       running,
  output logic       time_up,
  output logic       warning
);

  localparam int                   PRESC_W    = $clog2(CLKS_PER_SEC);
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(CLKS_PER_SEC - 1);

  timer_state_t       state;
  timer_state_t       nextState;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] prescNext;
  logic [7:0]         bonusSum;
  logic               bonusValid;
  logic               countZero;
  logic               startHit;
  logic               expiring;
  logic               bonusLoad;
  logic               strobeNext;

  bcd_sat_adder bonusAdder (
    .addendA (count_bcd),
    .addendB (bonus_bcd),
    .sum     (bonusSum),
    .inValid (bonusValid)
  );

  // Event arbitration: start beats everything, expiry beats pause, pause beats bonus
  always_comb begin
    countZero = (count_bcd == BCD_ZERO);
    startHit  = start && (state != ST_LOAD);
    expiring  = (state == ST_RUN) && countZero && !startHit;
    bonusLoad = bonus_req && bonusValid && ((state == ST_RUN) || (state == ST_PAUSE))
                && !startHit && !pause_toggle && !expiring;
  end

  // Next-state decode
  always_comb begin
    nextState = state;
    if (startHit) begin
      nextState = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD:  nextState = ST_RUN;
        ST_RUN: begin
          if (expiring)          nextState = ST_EXPIRED;
          else if (pause_toggle) nextState = ST_PAUSE;
        end
        ST_PAUSE: if (pause_toggle) nextState = ST_RUN;
        default:  nextState = state;
      endcase
    end
  end

  // Prescaler advances only in RUN; a bonus load on the terminal cycle holds it there one more cycle
  always_comb begin
    prescNext  = presc;
    strobeNext = 1'b0;
    if (state == ST_LOAD) begin
      prescNext = '0;
    end else if ((state == ST_RUN) && !startHit && !expiring) begin
      if (presc == PRESC_LAST) begin
        if (!bonusLoad) begin
          strobeNext = 1'b1;
          prescNext  = '0;
        end
      end else begin
        prescNext = presc + 1'b1;
      end
    end
  end

  // State, prescaler and registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= ST_IDLE;
      presc       <= '0;
      cnt_ena     <= 1'b0;
      cnt_ena_cnt <= 1'b0;
      cnt_loadN   <= 1'b1;
      cnt_data    <= INIT_TIME;
      running     <= 1'b0;
      time_up     <= 1'b0;
      warning     <= 1'b0;
    end else begin
      state       <= nextState;
      presc       <= prescNext;
      cnt_ena     <= (nextState != ST_IDLE);
      cnt_ena_cnt <= strobeNext;
      cnt_loadN   <= !(startHit || bonusLoad);
      if (startHit)       cnt_data <= INIT_TIME;
      else if (bonusLoad) cnt_data <= bonusSum;
      running     <= (nextState == ST_RUN);
      time_up     <= expiring;
      warning     <= ((state == ST_RUN) || (state == ST_PAUSE)) && !countZero
                     && (count_bcd <= WARN_TIME);
    end
  end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb/tb_countdown_timer_ctrl.sv - self-checking bench for countdown_timer_ctrl with a BCD counter model
module tb_countdown_timer_ctrl;
  import countdown_timer_pkg::*;

  logic       clk;
  logic       resetN;
  logic       start;
  logic       pause_toggle;
  logic       bonus_req;
  logic [7:0] bonus_bcd;
  logic [7:0] count_bcd;
  logic       cnt_ena;
  logic       cnt_ena_cnt;
  logic       cnt_loadN;
  logic [7:0] cnt_data;
  logic       running;
  logic       time_up;
  logic       warning;

  logic       setReq;
  logic [7:0] setVal;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int overlapCnt = 0;
  int strobeQ[$];
  int timeUpQ[$];

  typedef struct {
    int         due;
    logic       expLoadN;
    logic [7:0] expData;
    string      name;
  } sbEntry_t;
  sbEntry_t sbQ[$];

  typedef struct {
    logic [7:0] countVal;
    logic [7:0] bonus;
    logic       accept;
    logic [7:0] sum;
  } bonusVec_t;
  bonusVec_t vecs[10];

  countdown_timer_ctrl #(
    .CLKS_PER_SEC (4),
    .INIT_TIME    (8'h03),
    .WARN_TIME    (8'h02)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .start        (start),
    .pause_toggle (pause_toggle),
    .bonus_req    (bonus_req),
    .bonus_bcd    (bonus_bcd),
    .count_bcd    (count_bcd),
    .cnt_ena      (cnt_ena),
    .cnt_ena_cnt  (cnt_ena_cnt),
    .cnt_loadN    (cnt_loadN),
    .cnt_data     (cnt_data),
    .running      (running),
    .time_up      (time_up),
    .warning      (warning)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] bcdDec(input logic [7:0] v);
    if (v[3:0] != 4'd0)      return {v[7:4], v[3:0] - 4'd1};
    else if (v[7:4] != 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return 8'h99;
  endfunction

  // Two-digit BCD down-counter the controller drives; the bench can force a value
  always @(posedge clk or negedge resetN) begin
    if (!resetN)                   count_bcd <= 8'h00;
    else if (setReq)               count_bcd <= setVal;
    else if (!cnt_loadN)           count_bcd <= cnt_data;
    else if (cnt_ena && cnt_ena_cnt) count_bcd <= bcdDec(count_bcd);
  end

  // Event recorder for strobes, expiry pulses and load/strobe collisions
  always @(negedge clk) begin
    if (resetN) begin
      if (cnt_ena_cnt) strobeQ.push_back(cyc);
      if (time_up) timeUpQ.push_back(cyc);
      if (cnt_ena_cnt && !cnt_loadN) overlapCnt <= overlapCnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sbPush(input string name, input int due, input logic ld, input logic [7:0] d);
    sbEntry_t e;
    e.name = name;
    e.due = due;
    e.expLoadN = ld;
    e.expData = d;
    sbQ.push_back(e);
  endtask

  task automatic sbService();
    sbEntry_t e;
    while (sbQ.size() > 0 && sbQ[0].due <= cyc) begin
      e = sbQ.pop_front();
      check({e.name, "_loadN"}, 32'(cnt_loadN), 32'(e.expLoadN));
      if (!e.expLoadN) check({e.name, "_data"}, 32'(cnt_data), 32'(e.expData));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sbService();
  endtask

  int r0;
  int p;
  int sBase;
  int tBase;
  int pauseRunHigh;

  initial begin
    vecs[0] = '{8'h05, 8'h07, 1'b1, 8'h12};
    vecs[1] = '{8'h95, 8'h09, 1'b1, 8'h99};
    vecs[2] = '{8'h05, 8'h0A, 1'b0, 8'h00};
    vecs[3] = '{8'h42, 8'hA0, 1'b0, 8'h00};
    vecs[4] = '{8'h19, 8'h01, 1'b1, 8'h20};
    vecs[5] = '{8'h50, 8'h49, 1'b1, 8'h99};
    vecs[6] = '{8'h99, 8'h01, 1'b1, 8'h99};
    vecs[7] = '{8'h12, 8'hF3, 1'b0, 8'h00};
    vecs[8] = '{8'h09, 8'h09, 1'b1, 8'h18};
    vecs[9] = '{8'h37, 8'h25, 1'b1, 8'h62};

    resetN = 1'b0;
    start = 1'b0;
    pause_toggle = 1'b0;
    bonus_req = 1'b0;
    bonus_bcd = 8'h00;
    setReq = 1'b0;
    setVal = 8'h00;
    #12;
    check("rst_ena", 32'(cnt_ena), 0);
    check("rst_ena_cnt", 32'(cnt_ena_cnt), 0);
    check("rst_loadN", 32'(cnt_loadN), 1);
    check("rst_data", 32'(cnt_data), 32'h03);
    check("rst_running", 32'(running), 0);
    check("rst_time_up", 32'(time_up), 0);
    check("rst_warning", 32'(warning), 0);
    @(negedge clk);
    resetN = 1'b1;
    tick();
    tick();

    // Full round: load 03, strobe every 4 cycles, single expiry pulse
    start = 1'b1;
    sbPush("start_load", cyc + 1, 1'b0, 8'h03);
    tick();
    start = 1'b0;
    check("load_ena", 32'(cnt_ena), 1);
    check("load_running", 32'(running), 0);
    tick();
    r0 = cyc;
    check("run_running", 32'(running), 1);
    check("run_loadN", 32'(cnt_loadN), 1);
    sBase = strobeQ.size();
    tBase = timeUpQ.size();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 2) check("warn_high_count", 32'(warning), 0);
      if (k == 7) check("warn_low_count", 32'(warning), 1);
    end
    check("round_strobe_count", 32'(strobeQ.size() - sBase), 3);
    check("strobe1_cycle", 32'((strobeQ.size() > sBase) ? strobeQ[sBase] - r0 : -1), 4);
    check("strobe2_cycle", 32'((strobeQ.size() > sBase + 1) ? strobeQ[sBase + 1] - r0 : -1), 8);
    check("strobe3_cycle", 32'((strobeQ.size() > sBase + 2) ? strobeQ[sBase + 2] - r0 : -1), 12);
    check("time_up_count", 32'(timeUpQ.size() - tBase), 1);
    check("time_up_cycle", 32'((timeUpQ.size() > tBase) ? timeUpQ[tBase] - r0 : -1), 14);
    check("expired_running", 32'(running), 0);
    check("expired_ena", 32'(cnt_ena), 1);
    check("expired_warning", 32'(warning), 0);

    // Pause after two prescaler cycles, resume keeps the partial second
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    pause_toggle = 1'b1;
    tick();
    pause_toggle = 1'b0;
    sBase = strobeQ.size();
    pauseRunHigh = 0;
    for (int k = 0; k < 10; k++) begin
      if (running) pauseRunHigh++;
      tick();
    end
    check("pause_running_high_cycles", 32'(pauseRunHigh), 0);
    check("pause_strobes", 32'(strobeQ.size() - sBase), 0);
    p = cyc;
    pause_toggle = 1'b1;
    tick();
    pause_toggle = 1'b0;
    check("resume_running", 32'(running), 1);
    check("resume_no_early_strobe", 32'(cnt_ena_cnt), 0);
    tick();
    check("resume_strobe_plus2", 32'(cnt_ena_cnt), 1);

    // Bonus load lands on the strobe cycle: strobe slips one cycle
    tick();
    tick();
    tick();
    bonus_req = 1'b1;
    bonus_bcd = 8'h01;
    sbPush("defer_load", cyc + 1, 1'b0, 8'h03);
    tick();
    bonus_req = 1'b0;
    check("defer_no_strobe_on_load", 32'(cnt_ena_cnt), 0);
    tick();
    check("defer_strobe_next", 32'(cnt_ena_cnt), 1);
    check("defer_loadN_released", 32'(cnt_loadN), 1);

    // start together with pause_toggle while running: reload and keep running
    start = 1'b1;
    pause_toggle = 1'b1;
    sbPush("start_pause_load", cyc + 1, 1'b0, 8'h03);
    tick();
    start = 1'b0;
    pause_toggle = 1'b0;
    tick();
    check("start_pause_running", 32'(running), 1);
    tick();
    tick();
    check("start_pause_still_running", 32'(running), 1);

    // Bonus table applied while paused
    pause_toggle = 1'b1;
    tick();
    pause_toggle = 1'b0;
    check("table_paused", 32'(running), 0);
    for (int i = 0; i < 10; i++) begin
      setReq = 1'b1;
      setVal = vecs[i].countVal;
      tick();
      setReq = 1'b0;
      bonus_req = 1'b1;
      bonus_bcd = vecs[i].bonus;
      sbPush($sformatf("bonus%0d", i), cyc + 1, !vecs[i].accept, vecs[i].sum);
      tick();
      bonus_req = 1'b0;
      tick();
    end
    check("scoreboard_drained", 32'(sbQ.size()), 0);

    // Asynchronous reset mid-run
    pause_toggle = 1'b1;
    tick();
    pause_toggle = 1'b0;
    check("pre_reset_running", 32'(running), 1);
    check("pre_reset_data", 32'(cnt_data), 32'h62);
    tick();
    #3;
    resetN = 1'b0;
    #1;
    check("arst_ena", 32'(cnt_ena), 0);
    check("arst_ena_cnt", 32'(cnt_ena_cnt), 0);
    check("arst_loadN", 32'(cnt_loadN), 1);
    check("arst_data", 32'(cnt_data), 32'h03);
    check("arst_running", 32'(running), 0);
    check("arst_time_up", 32'(time_up), 0);
    check("arst_warning", 32'(warning), 0);
    check("arst_state", 32'(dut.state), 32'(ST_IDLE));
    check("load_strobe_overlap", 32'(overlapCnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
